// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the board-level input conditioner.
package input_cond_pkg;

    localparam int IC_SYNC_STAGES_DEF = 2;
    localparam int IC_DB_CYCLES_DEF   = 250000;

    // Converts a debounce window in microseconds to clock cycles, never below 1.
    function automatic int ic_cycles_for_us(input longint clk_freq_hz, input int window_us);
        longint cyc;
        cyc = (clk_freq_hz * longint'(window_us)) / longint'(1_000_000);
        if (cyc < longint'(1)) cyc = longint'(1);
        return int'(cyc);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioner channel: optional inversion, synchroniser chain, debounce
// counter, registered level and (with INPUT_COND_EDGE_DETECT_EN) edge pulses.
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = IC_SYNC_STAGES_DEF,
    parameter int   DB_CYCLES   = IC_DB_CYCLES_DEF,
    parameter logic INIT_BIT    = 1'b0,
    parameter logic INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_channel: SYNC_STAGES must be at least 2");
    end
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("debounce_channel: DB_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   settle;

    assign s      = sync_q[SYNC_STAGES-1];
    // Disagreement has lasted the full window; this edge accepts the new level.
    assign settle = (s != dout) && (cnt == CNT_LAST);

    // Synchroniser chain; inversion happens before the first flop so the
    // chain always carries the logical (active-high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {SYNC_STAGES{INIT_BIT}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], din ^ INVERT};
    end

    // Debounce: any sample agreeing with the output restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= INIT_BIT;
        end else if (s == dout) begin
            cnt  <= '0;
        end else if (settle) begin
            cnt  <= '0;
            dout <= s;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

`ifdef INPUT_COND_EDGE_DETECT_EN
    // Edge pulses register on the same edge that updates dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= settle &&  s;
            fall <= settle && !s;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: WIDTH independent synchronise+debounce
// channels. Define INPUT_COND_EDGE_DETECT_EN to build the Rise/Fall/Changed
// edge outputs; without it they are tied low and Out is unaffected.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int               WIDTH       = 20,
    parameter int               SYNC_STAGES = IC_SYNC_STAGES_DEF,
    parameter int               DB_CYCLES   = IC_DB_CYCLES_DEF,
    parameter logic [WIDTH-1:0] INIT_VALUE  = '0,
    parameter logic [WIDTH-1:0] INVERT_MASK = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall,
    output logic             Changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .INIT_BIT    (INIT_VALUE[i]),
            .INVERT      (INVERT_MASK[i])
        ) u_ch (
            .clk  (Clk),
            .rst  (Reset),
            .din  (In[i]),
            .dout (Out[i]),
            .rise (Rise[i]),
            .fall (Fall[i])
        );
    end

`ifdef INPUT_COND_EDGE_DETECT_EN
    // Any channel event this cycle.
    assign Changed = |(Rise | Fall);
`else
    assign Changed = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (WIDTH=4, SYNC_STAGES=2, DB_CYCLES=4).
// Without INPUT_COND_EDGE_DETECT_EN the bench builds INVERT_MASK=4'b0001 and
// expects the edge outputs to stay low.
module tb_input_conditioner;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam logic [W-1:0] INIT = '0;
`ifdef INPUT_COND_EDGE_DETECT_EN
    localparam logic [W-1:0] MASK     = 4'b0000;
    localparam bit           EDGES_ON = 1'b1;
`else
    localparam logic [W-1:0] MASK     = 4'b0001;
    localparam bit           EDGES_ON = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] In, Out, Rise, Fall;
    logic         Changed;

    always #5 Clk = ~Clk;

    input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(SS), .DB_CYCLES(DB),
        .INIT_VALUE(INIT), .INVERT_MASK(MASK)
    ) dut (
        .Clk(Clk), .Reset(Reset), .In(In),
        .Out(Out), .Rise(Rise), .Fall(Fall), .Changed(Changed)
    );

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: s is the pin level seen SS edges late; a channel
    // accepts a new level once the last DB samples of s all disagree with it.
    logic [W-1:0] m_out;
    logic [W-1:0] m_dline[$];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_s, m_r, m_f;
    bit           all_diff;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_out   = INIT;
            m_dline = {};
            for (int k = 0; k < SS; k++) m_dline.push_back(INIT);
            m_hist  = {};
            if (Clk) exp_q.push_back('{out: INIT, rise: '0, fall: '0, changed: 1'b0});
        end else begin
            m_s = m_dline[SS-1];
            m_dline.push_front(In ^ MASK);
            void'(m_dline.pop_back());
            m_hist.push_back(m_s);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            m_r = '0;
            m_f = '0;
            for (int i = 0; i < W; i++) begin
                all_diff = (m_hist.size() == DB);
                foreach (m_hist[k]) if (m_hist[k][i] == m_out[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_out[i] = ~m_out[i];
                    if (m_out[i]) m_r[i] = 1'b1;
                    else          m_f[i] = 1'b1;
                end
            end
            if (!EDGES_ON) begin
                m_r = '0;
                m_f = '0;
            end
            exp_q.push_back('{out: m_out, rise: m_r, fall: m_f, changed: |(m_r | m_f)});
        end
    end

    // Monitor: compare each cycle's outputs against the model's prediction.
    exp_t e;
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_out",     Out,         e.out);
            check("sb_rise",    Rise,        e.rise);
            check("sb_fall",    Fall,        e.fall);
            check("sb_changed", W'(Changed), W'(e.changed));
        end
    end

    // Counts edges from now until Out[ch] reaches target (bounded).
    task automatic measure(input int ch, input logic target, input int want, input string name);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge Clk);
            #1;
            n++;
            if (Out[ch] === target) seen = 1'b1;
        end
        check_n(name, n, want);
    endtask

    // Reset asserted and released in the low phase of the clock.
    task automatic pulse_reset(input int hold, input bit check_now);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        if (check_now) begin
            check("async_out",     Out,         INIT);
            check("async_rise",    Rise,        '0);
            check("async_fall",    Fall,        '0);
            check("async_changed", W'(Changed), '0);
        end
        repeat (hold) @(posedge Clk);
        @(negedge Clk);
        #2 Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        // Channel 0 held at logical 1 through reset (In[0]=0 when inverted).
        In = {3'b000, ~MASK[0]};
        #1 Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        #2 Reset = 1'b0;
        measure(0, 1'b1, SS + DB, "release_latency");
        check("release_rise", Rise, EDGES_ON ? 4'b0001 : 4'b0000);
        repeat (3) @(negedge Clk);

        // Clean steps on channel 0: fall then rise.
        In[0] = MASK[0];
        measure(0, 1'b0, SS + DB, "step_fall_latency");
        check("step_fall", Fall, EDGES_ON ? 4'b0001 : 4'b0000);
        @(negedge Clk);
        check("step_fall_once", Fall, '0);
        repeat (3) @(negedge Clk);
        In[0] = ~MASK[0];
        measure(0, 1'b1, SS + DB, "step_rise_latency");
        check("step_changed", W'(Changed), EDGES_ON ? 4'b0001 : 4'b0000);
        repeat (3) @(negedge Clk);

        // Bounce on channel 1: 3 cycles high is rejected, a held high is accepted.
        In[1] = 1'b1;
        repeat (3) @(negedge Clk);
        In[1] = 1'b0;
        repeat (12) @(negedge Clk);
        check("bounce_hold", Out & 4'b0010, 4'b0000);
        In[1] = 1'b1;
        measure(1, 1'b1, SS + DB, "bounce_accept_latency");
        repeat (3) @(negedge Clk);

        // Parallel channels: channel 3 high first, then 2 rises as 3 falls.
        In[3] = 1'b1;
        measure(3, 1'b1, SS + DB, "ch3_set_latency");
        repeat (3) @(negedge Clk);
        In[2] = 1'b1;
        In[3] = 1'b0;
        measure(2, 1'b1, SS + DB, "parallel_latency");
        check("par_out",  Out & 4'b1100, 4'b0100);
        check("par_rise", Rise, EDGES_ON ? 4'b0100 : 4'b0000);
        check("par_fall", Fall, EDGES_ON ? 4'b1000 : 4'b0000);
        check("par_changed", W'(Changed), EDGES_ON ? 4'b0001 : 4'b0000);
        @(negedge Clk);
        check("par_changed_once", W'(Changed), '0);

        // Asynchronous reset with several outputs high.
        pulse_reset(3, 1'b1);
        measure(1, 1'b1, SS + DB, "post_reset_relatch");
        repeat (3) @(negedge Clk);

        // Reset in the middle of a count on channel 0.
        In[0] = MASK[0];
        repeat (10) @(negedge Clk);
        In[0] = ~MASK[0];
        @(posedge Clk);
        @(posedge Clk);
        pulse_reset(2, 1'b0);
        measure(0, 1'b1, SS + DB, "midcount_reset_latency");
        check("midcount_rise", Rise & 4'b0001, EDGES_ON ? 4'b0001 : 4'b0000);

        // Random pin activity with occasional resets.
        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            if ($urandom_range(3) == 0) In[$urandom_range(W - 1)] ^= 1'b1;
            if (c == 150 || c == 300) begin
                #2 Reset = 1'b1;
                repeat (2) @(posedge Clk);
                @(negedge Clk);
                #2 Reset = 1'b0;
            end
        end
        repeat (12) @(negedge Clk);
        #1;
        check_n("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioner for the board-level top of the SLC-3 lab designs. It succeeds the single-bit two-flop `sync` instances: each of WIDTH asynchronous switch/button inputs gets a configurable-depth synchroniser, a per-channel debounce counter and optional one-cycle edge pulses. It sits between the board pins (switches, KEYs) and the CPU core, so the core only sees clean, clock-domain-safe levels and single-cycle press events.

## Interface
- WIDTH, 20 — number of independent channels.
- SYNC_STAGES, 2 — synchroniser flops per channel; must be ≥ 2. Any smaller value is an elaboration error.
- DB_CYCLES, 250000 — consecutive stable samples required to accept a new level (5 ms at 50 MHz); must be ≥ 1. DB_CYCLES = 1 disables debouncing.
- INIT_VALUE, '0 — WIDTH-bit reset value of the synchroniser flops and of Out.
- INVERT_MASK, '0 — WIDTH-bit mask; bits set are inverted before synchronisation, for active-low KEYs.

Ports:
- Clk  input  1  — system clock. All state changes on its rising edge.
- Reset  input  1  — asynchronous, active-high reset.
- In  input  WIDTH  — raw asynchronous pin levels.
- Out  output  WIDTH  — debounced level, registered.
- Rise  output  WIDTH  — one-cycle pulse when Out[i] goes 0→1, registered.
- Fall  output  WIDTH  — one-cycle pulse when Out[i] goes 1→0, registered.
- Changed  output  1  — OR-reduction of Rise|Fall, combinational.

## Operation
- Each channel is independent. There is no cross-channel state.
- Input path: `d = In[i] ^ INVERT_MASK[i]` feeds a SYNC_STAGES shift chain. The last stage is `s[i]`.
- Per-channel counter:
  - Width is `$clog2(DB_CYCLES+1)`.
  - If `s[i] == Out[i]`, then `cnt <= 0`.
  - If `s[i] != Out[i]` and `cnt == DB_CYCLES-1`, then `Out[i] <= s[i]` and `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
- Any disagreement shorter than DB_CYCLES samples is a glitch or bounce. The counter returns to 0 and Out does not change.
- Edge pulses are registered on the same edge that updates Out:
  - `Rise[i] <= (s!=Out) && cnt==DB_CYCLES-1 && s==1`.
  - Fall is the mirror of Rise.
  - Each pulse is high for exactly one cycle.
- Reset is asynchronous and takes effect immediately, including mid-count:
  - Sync flops and Out go to INIT_VALUE.
  - All counters go to 0.
  - Rise and Fall go to 0.
- Nothing pulses during reset or on reset release. If pins differ from INIT_VALUE at release, Out updates after the full normal latency and the corresponding Rise/Fall pulse fires.

## Timing
- Reset values: Out = INIT_VALUE, Rise = 0, Fall = 0, Changed = 0.
- Latency: In changes and meets setup before edge 0. s reflects the change after edge SYNC_STAGES, and Out changes on edge SYNC_STAGES + DB_CYCLES. Rise/Fall are high for the cycle following that edge.
- Defaults give 2 + 250000 cycles.
- A change that reverts before edge SYNC_STAGES + DB_CYCLES produces no output activity.
- Changed is valid in the same cycle as Rise/Fall.

## Configuration
- Macro: INPUT_COND_EDGE_DETECT_EN.
- Defined: Rise, Fall and Changed behave as specified above.
- Undefined:
  - Edge registers are not built.
  - Rise, Fall and Changed are tied to 0.
  - Out behaviour and latency are unchanged.

## Structure
- Package `input_cond_pkg` holds:
  - Default constants `IC_SYNC_STAGES_DEF` and `IC_DB_CYCLES_DEF`.
  - A `clk_freq_hz`-to-cycles helper function for computing DB_CYCLES.
- Sub-module `debounce_channel` contains one channel: sync chain, counter, Out bit and edge bits. The top generates WIDTH instances and ORs the pulses to form Changed.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2, DB_CYCLES=4, INIT_VALUE=0, INVERT_MASK=0, with the macro defined unless noted.
- **Reset:** assert Reset asynchronously mid-cycle. Expect Out=0, Rise=0, Fall=0, Changed=0 immediately, with no clock edge needed.
- **Clean step:** In[0] goes 0→1 before edge 0. Expect Out[0]=1 after edge 6, Rise[0]=1 and Changed=1 for exactly the cycle after edge 6, then 0. In[0] then goes 1→0, giving a Fall[0] pulse 6 edges later.
- **Bounce:** In[1] is high for 3 cycles then low. Expect Out[1] to stay 0 and no pulses. A later 4-cycle high followed by a hold gives Out[1]=1 at the expected edge.
- **Parallel channels:** In[2] rises and In[3] falls (Out[3] previously 1) at the same time. Expect Rise[2] and Fall[3] in the same cycle and Changed=1 for one cycle.
- **Reset mid-count:** assert Reset 2 edges after In[0] rises, then release. Expect Out[0] to rise exactly 6 edges after the first post-release edge, followed by Rise[0].
- **Inversion and macro off:**
  - Build INVERT_MASK=4'b0001 with the macro undefined.
  - Hold In[0]=0 through reset.
  - Expect Out[0]=1 after edge 6 following release.
  - Expect Rise, Fall and Changed to remain 0 throughout.
